s2p_symbol_scheduler: RTL

//  Frame-level controller for the baseband serial-to-parallel stage: groups an incoming serial bit stream

---
 rtl/s2p_ctrl_pkg.sv | 30 +++
 rtl/s2p_bit_collector.sv | 71 +++++++
 rtl/s2p_symbol_scheduler.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/s2p_ctrl_pkg.sv
// rtl/s2p_ctrl_pkg.sv - shared types and helpers for the serial-to-parallel symbol scheduler
// Purpose: FSM state enum, modulation codes, bits-per-symbol lookup, default widths.
// Ports: none (package).
package s2p_ctrl_pkg;

    localparam int MAX_BPS_DEF = 6;
    localparam int BPS_W       = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [1:0] MOD_BPSK  = 2'b00;
    localparam logic [1:0] MOD_QPSK  = 2'b01;
    localparam logic [1:0] MOD_QAM16 = 2'b10;
    localparam logic [1:0] MOD_QAM64 = 2'b11;

    function automatic logic [BPS_W-1:0] bps_of(input logic [1:0] mod);
        case (mod)
            MOD_BPSK:  bps_of = 3'd1;
            MOD_QPSK:  bps_of = 3'd2;
            MOD_QAM16: bps_of = 3'd4;
            default:   bps_of = 3'd6;
        endcase
    endfunction

endpackage

// File: rtl/s2p_bit_collector.sv
// rtl/s2p_bit_collector.sv - assembles serial bits into one symbol and holds it until cleared
// Purpose: bit-index counter plus symbol register; first loaded bit lands at bit 0.
// Ports:
//   clk, rst_ni     clock, asynchronous active-low reset
//   bit_i, load_i   serial bit and its load strobe (ignored while full)
//   clear_i         discard contents (wins over load_i)
//   bps_i           bits per symbol for the current frame
//   full_o          a complete symbol is held
//   done_o          the bit loaded this cycle completes the symbol
//   sym_o           held symbol, unused upper bits are 0
module s2p_bit_collector
    import s2p_ctrl_pkg::*;
#(
    parameter int MAX_BPS = MAX_BPS_DEF
) (
    input  logic               clk,
    input  logic               rst_ni,
    input  logic               bit_i,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic [BPS_W-1:0]   bps_i,
    output logic               full_o,
    output logic               done_o,
    output logic [MAX_BPS-1:0] sym_o
);

    logic [BPS_W-1:0]   idx_q, idx_d;
    logic [MAX_BPS-1:0] sym_q, sym_d;
    logic               full_q, full_d;
    logic               take;
    logic               last_bit;

    assign take     = load_i & ~full_q;
    assign last_bit = (idx_q == (bps_i - BPS_W'(1)));
    assign done_o   = take & last_bit & ~clear_i;

    always_comb begin
        idx_d  = idx_q;
        sym_d  = sym_q;
        full_d = full_q;
        if (clear_i) begin
            idx_d  = '0;
            sym_d  = '0;
            full_d = 1'b0;
        end else if (take) begin
            sym_d[idx_q] = bit_i;
            if (last_bit) begin
                full_d = 1'b1;
                idx_d  = '0;
            end else begin
                idx_d = idx_q + BPS_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q  <= '0;
            sym_q  <= '0;
            full_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            sym_q  <= sym_d;
            full_q <= full_d;
        end
    end

    assign full_o = full_q;
    assign sym_o  = sym_q;

endmodule

// File: rtl/s2p_symbol_scheduler.sv
// rtl/s2p_symbol_scheduler.sv - frame-level serial-to-parallel symbol scheduler feeding the mapper
// Purpose: groups serial bits into 1/2/4/6-bit symbols, presents them with valid/ready, counts
//   symbols per frame, flags the last one and pulses frame_done. Optional macro S2P_OVERLAP_EN
//   adds a second collector so the next symbol assembles while the current one waits.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   cfg_mod, frame_len          modulation and symbol count, sampled on an accepted frame_start
//   frame_start, abort          frame request, abort of the running frame
//   bit_in, bit_valid, bit_ready   serial bit stream handshake
//   sym_out, sym_valid, sym_ready, sym_last   symbol handshake towards the mapper
//   busy, frame_done            activity flag, one-cycle completion pulse
module s2p_symbol_scheduler
    import s2p_ctrl_pkg::*;
#(
    parameter int MAX_BPS     = MAX_BPS_DEF,
    parameter int FRAME_LEN_W = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             cfg_mod,
    input  logic [FRAME_LEN_W-1:0] frame_len,
    input  logic                   frame_start,
    input  logic                   abort,
    input  logic                   bit_in,
    input  logic                   bit_valid,
    output logic                   bit_ready,
    output logic [MAX_BPS-1:0]     sym_out,
    output logic                   sym_valid,
    input  logic                   sym_ready,
    output logic                   sym_last,
    output logic                   busy,
    output logic                   frame_done
);

    state_e                 state_q, state_d;
    logic [BPS_W-1:0]       bps_q, bps_d;
    logic [FRAME_LEN_W-1:0] cnt_q, cnt_d;     // symbols still to be handed to the mapper
    logic                   zdone_q, zdone_d; // completion pulse for a zero-length frame
    logic                   start_ok, kill, accept, hs;
    logic                   col_done, cur_full, next_ready;
    logic [MAX_BPS-1:0]     cur_sym;

    assign start_ok = (state_q == IDLE) & frame_start;
    assign kill     = abort & (state_q != IDLE);
    assign accept   = bit_valid & bit_ready;
    // abort takes priority over a coincident sym_ready
    assign hs       = sym_valid & sym_ready & ~abort;

`ifdef S2P_OVERLAP_EN
    logic                   rd_q, rd_d, wr_q, wr_d;
    logic [FRAME_LEN_W-1:0] left_q, left_d;   // symbols not yet assembled
    logic [1:0]             full_b, done_b;
    logic [MAX_BPS-1:0]     sym_b [2];

    // Ping-pong buffers: wr_q fills, rd_q is presented to the mapper.
    for (genvar g = 0; g < 2; g++) begin : g_col
        s2p_bit_collector #(.MAX_BPS(MAX_BPS)) u_col (
            .clk     (clk),
            .rst_ni  (rst),
            .bit_i   (bit_in),
            .load_i  (accept & (wr_q == 1'(g))),
            .clear_i (kill | (hs & (rd_q == 1'(g)))),
            .bps_i   (bps_q),
            .full_o  (full_b[g]),
            .done_o  (done_b[g]),
            .sym_o   (sym_b[g])
        );
    end

    assign col_done   = |done_b;
    assign cur_full   = full_b[rd_q];
    assign cur_sym    = sym_b[rd_q];
    assign next_ready = full_b[~rd_q] | col_done;
    // Stop collecting once every symbol of the frame has been assembled.
    assign bit_ready  = ((state_q == COLLECT) | (state_q == HOLD)) & ~full_b[wr_q] & (left_q != '0);

    always_comb begin
        rd_d   = rd_q;
        wr_d   = wr_q;
        left_d = left_q;
        if (start_ok) begin
            rd_d   = 1'b0;
            wr_d   = 1'b0;
            left_d = frame_len;
        end else if (kill) begin
            rd_d   = 1'b0;
            wr_d   = 1'b0;
            left_d = '0;
        end else begin
            if (hs) rd_d = ~rd_q;
            if (col_done) begin
                wr_d   = ~wr_q;
                left_d = left_q - FRAME_LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            left_q <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            left_q <= left_d;
        end
    end
`else
    s2p_bit_collector #(.MAX_BPS(MAX_BPS)) u_col (
        .clk     (clk),
        .rst_ni  (rst),
        .bit_i   (bit_in),
        .load_i  (accept),
        .clear_i (kill | hs),
        .bps_i   (bps_q),
        .full_o  (cur_full),
        .done_o  (col_done),
        .sym_o   (cur_sym)
    );

    assign next_ready = 1'b0;
    assign bit_ready  = (state_q == COLLECT);
`endif

    assign sym_valid  = (state_q == HOLD) & cur_full;
    assign sym_out    = sym_valid ? cur_sym : '0;
    assign sym_last   = sym_valid & (cnt_q == FRAME_LEN_W'(1));
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE) | zdone_q;

    always_comb begin
        state_d = state_q;
        bps_d   = bps_q;
        cnt_d   = cnt_q;
        zdone_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    if (frame_len != '0) begin
                        state_d = COLLECT;
                        bps_d   = bps_of(cfg_mod);
                        cnt_d   = frame_len;
                    end else begin
                        zdone_d = 1'b1;
                    end
                end
            end
            COLLECT: if (col_done) state_d = HOLD;
            HOLD: begin
                if (hs) begin
                    cnt_d = cnt_q - FRAME_LEN_W'(1);
                    if (cnt_q == FRAME_LEN_W'(1)) state_d = DONE;
                    else if (next_ready)          state_d = HOLD;
                    else                          state_d = COLLECT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            bps_q   <= '0;
            cnt_q   <= '0;
            zdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bps_q   <= bps_d;
            cnt_q   <= cnt_d;
            zdone_q <= zdone_d;
        end
    end

endmodule
